// File: rtl/tick_divider.sv
// Programmable tick generator: one-cycle tick every div_cur enabled cycles, with oneshot HALT.
// Define TICK_DIVIDER_CLKOUT_EN to build the clk_out square-wave register (else clk_out is 0).
module tick_divider #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DIV_DEFAULT = 25000000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             oneshot,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             clk_out,
    output logic [CNT_W-1:0] tick_count,
    output logic [WIDTH-1:0] div_cur,
    output logic             busy
);

    // A divisor of zero behaves as one: tick on every enabled cycle.
    localparam logic [WIDTH-1:0] DivReset =
        (DIV_DEFAULT == 32'd0) ? WIDTH'(1) : WIDTH'(DIV_DEFAULT);

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   div_cur_q, div_cur_d;
    logic [WIDTH-1:0]   div_pend_q, div_pend_d;
    logic               tick_q, tick_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               at_end;

    // div_cur is never zero, so the subtraction cannot underflow.
    assign at_end = (cnt_q >= (div_cur_q - WIDTH'(1)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        tick_d     = 1'b0;
        count_d    = count_q;

        if (div_load) begin
            div_pend_d = (div_in == '0) ? WIDTH'(1) : div_in;
        end

        if (clear) begin
            state_d   = StRun;
            cnt_d     = '0;
            div_cur_d = div_pend_q;
        end else begin
            unique case (state_q)
                StHalt: begin
                    cnt_d     = '0;
                    div_cur_d = div_pend_q;
                end
                StRun: begin
                    if (enable) begin
                        if (at_end) begin
                            cnt_d     = '0;
                            tick_d    = 1'b1;
                            div_cur_d = div_pend_q;
                            count_d   = count_q + CNT_W'(1);
                            if (oneshot) begin
                                state_d = StHalt;
                            end
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            div_cur_q  <= DivReset;
            div_pend_q <= DivReset;
            tick_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
        end
    end

`ifdef TICK_DIVIDER_CLKOUT_EN
    logic clk_out_q, clk_out_d;

    always_comb begin
        clk_out_d = clk_out_q;
        if (tick_d) begin
            clk_out_d = ~clk_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_out_q <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;
`else
    assign clk_out = 1'b0;
`endif

    assign tick       = tick_q;
    assign tick_count = count_q;
    assign div_cur    = div_cur_q;
    assign busy       = (state_q == StRun);

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider (DIV_DEFAULT=4, CNT_W=4); clk_out expectation follows
// TICK_DIVIDER_CLKOUT_EN, tick expectations are the same for both builds.
module tb_tick_divider;

    localparam int unsigned W = 16;

`ifdef TICK_DIVIDER_CLKOUT_EN
    localparam bit ClkOn = 1'b1;
`else
    localparam bit ClkOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic         oneshot = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         tick;
    logic         clk_out;
    logic [3:0]   tick_count;
    logic [W-1:0] div_cur;
    logic         busy;

    int total = 0;
    int bad = 0;

    tick_divider #(
        .WIDTH      (W),
        .DIV_DEFAULT(4),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .oneshot   (oneshot),
        .div_load  (div_load),
        .div_in    (div_in),
        .tick      (tick),
        .clk_out   (clk_out),
        .tick_count(tick_count),
        .div_cur   (div_cur),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        clear   = 1'b0;
        oneshot = 1'b0;
        div_load = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Load a divisor and apply it with clear; leaves counter at 0 with no tick issued.
    task automatic set_div(input logic [W-1:0] v);
        div_in   = v;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({tick, clk_out, tick_count, busy} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs: got tick=%0b clk_out=%0b cnt=%0d busy=%0b want 0 0 0 1",
                     tick, clk_out, tick_count, busy);
        end
        total++;
        if (div_cur !== W'(4)) begin
            bad++;
            $display("FAIL reset_div_cur: got %0d want 4", div_cur);
        end
    endtask

    task automatic test_basic();
        logic exp_clk;
        exp_clk = 1'b0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i % 4 == 0) exp_clk = ~exp_clk;
            total++;
            if (tick !== (i % 4 == 0)) begin
                bad++;
                $display("FAIL basic_tick cycle %0d: got %0b want %0b", i, tick, (i % 4 == 0));
            end
            total++;
            if (clk_out !== (exp_clk & ClkOn)) begin
                bad++;
                $display("FAIL basic_clk_out cycle %0d: got %0b want %0b", i, clk_out,
                         exp_clk & ClkOn);
            end
        end
        total++;
        if (tick_count !== 4'd3) begin
            bad++;
            $display("FAIL basic_count: got %0d want 3", tick_count);
        end
    endtask

    task automatic test_div_load();
        logic exp_tick;
        do_reset();
        set_div(W'(5));
        total++;
        if (div_cur !== W'(5)) begin
            bad++;
            $display("FAIL load_setup_div: got %0d want 5", div_cur);
        end
        for (int i = 1; i <= 14; i++) begin
            div_load = (i == 2) || (i == 9);
            div_in   = (i == 9) ? W'(3) : W'(2);
            step();
            div_load = 1'b0;
            exp_tick = (i == 5) || (i == 7) || (i == 9) || (i == 11) || (i == 14);
            total++;
            if (tick !== exp_tick) begin
                bad++;
                $display("FAIL load_tick cycle %0d: got %0b want %0b", i, tick, exp_tick);
            end
            if (i == 4 || i == 5 || i == 9 || i == 11) begin
                total++;
                if (div_cur !== ((i == 4) ? W'(5) : (i == 11) ? W'(3) : W'(2))) begin
                    bad++;
                    $display("FAIL load_div_cur cycle %0d: got %0d", i, div_cur);
                end
            end
        end
        total++;
        if (tick_count !== 4'd5) begin
            bad++;
            $display("FAIL load_count: got %0d want 5", tick_count);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        set_div(W'(3));
        oneshot = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (tick !== (i == 3)) begin
                bad++;
                $display("FAIL oneshot_tick cycle %0d: got %0b want %0b", i, tick, (i == 3));
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_halt_busy: got %0b want 0", busy);
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            total++;
            if (tick !== 1'b0 || busy !== 1'b0 || tick_count !== 4'd1) begin
                bad++;
                $display("FAIL halt_hold cycle %0d: got tick=%0b busy=%0b cnt=%0d want 0 0 1",
                         i, tick, busy, tick_count);
            end
        end
        total++;
        if (clk_out !== ClkOn) begin
            bad++;
            $display("FAIL halt_clk_out: got %0b want %0b", clk_out, ClkOn);
        end
        oneshot = 1'b0;
        clear   = 1'b1;
        step();
        clear   = 1'b0;
        total++;
        if (busy !== 1'b1 || tick !== 1'b0) begin
            bad++;
            $display("FAIL clear_resume: got busy=%0b tick=%0b want 1 0", busy, tick);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (tick !== (i == 3)) begin
                bad++;
                $display("FAIL resume_tick cycle %0d: got %0b want %0b", i, tick, (i == 3));
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        set_div(W'(6));
        for (int i = 1; i <= 16; i++) begin
            enable = !(i >= 3 && i <= 12);
            step();
            total++;
            if (tick !== (i == 16)) begin
                bad++;
                $display("FAIL enable_hold_tick cycle %0d: got %0b want %0b", i, tick, (i == 16));
            end
        end
        enable = 1'b1;
        for (int i = 17; i <= 28; i++) begin
            clear = (i == 22);
            step();
            clear = 1'b0;
            total++;
            if (tick !== (i == 28)) begin
                bad++;
                $display("FAIL clear_wrap_tick cycle %0d: got %0b want %0b", i, tick, (i == 28));
            end
        end
        total++;
        if (tick_count !== 4'd2) begin
            bad++;
            $display("FAIL clear_wrap_count: got %0d want 2", tick_count);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        set_div(W'(0));
        total++;
        if (div_cur !== W'(1)) begin
            bad++;
            $display("FAIL zero_div_cur: got %0d want 1", div_cur);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            total++;
            if (tick !== 1'b1 || tick_count !== 4'(i % 16)) begin
                bad++;
                $display("FAIL wrap_count tick %0d: got tick=%0b cnt=%0d want 1 %0d",
                         i, tick, tick_count, i % 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_div(W'(8));
        for (int i = 1; i <= 3; i++) begin
            div_load = (i == 3);
            div_in   = W'(2);
            step();
            div_load = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({tick, clk_out, tick_count, busy} !== {1'b0, 1'b0, 4'd0, 1'b1}
            || div_cur !== W'(4)) begin
            bad++;
            $display("FAIL midreset_state: got tick=%0b clk_out=%0b cnt=%0d busy=%0b div=%0d",
                     tick, clk_out, tick_count, busy, div_cur);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (tick !== (i % 4 == 0) || div_cur !== W'(4)) begin
                bad++;
                $display("FAIL midreset_tick cycle %0d: got tick=%0b div=%0d want %0b 4",
                         i, tick, div_cur, (i % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_load();
        test_oneshot();
        test_enable();
        test_count_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter WIDTH, default 32: width of the phase counter, divisor and divisor ports.
REQ-002 Parameter DIV_DEFAULT, default 25000000: divisor loaded at reset (one tick per second at 25 MHz).
REQ-003 Parameter CNT_W, default 16: width of tick_count.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port enable  input  1: phase counter advances only while high.
REQ-007 Port clear  input  1: restarts the period and exits HALT.
REQ-008 Port oneshot  input  1: when high, the block halts after the next tick.
REQ-009 Port div_load  input  1: single-cycle strobe capturing div_in.
REQ-010 Port div_in  input  WIDTH: new divisor value.
REQ-011 Port tick  output  1: one-cycle pulse at the end of each period.
REQ-012 Port clk_out  output  1: square wave that toggles on every tick.
REQ-013 Port tick_count  output  CNT_W: number of ticks since reset.
REQ-014 Port div_cur  output  WIDTH: active divisor.
REQ-015 Port busy  output  1: high in RUN, low in HALT.

Function
REQ-016 The block SHALL have two states, RUN and HALT:
- RUN goes to HALT on a tick while oneshot=1.
- HALT goes to RUN on clear=1.
REQ-017 In RUN with enable=1, the phase counter SHALL count 0..div_cur-1 and then wrap to 0.
REQ-018 tick SHALL be registered and high for exactly the one cycle after the counter held div_cur-1 with enable=1, giving a period of exactly div_cur enabled cycles.
REQ-019 A div_in or DIV_DEFAULT value of 0 SHALL be treated as 1, giving a tick on every enabled cycle.
REQ-020 With enable=0, the counter SHALL hold its value, no tick SHALL occur, and counting SHALL resume from the held value.
REQ-021 div_load SHALL write div_in into a pending register; last strobe wins.
REQ-022 The pending divisor SHALL move to div_cur:
- at the period wrap in RUN, or
- on the next cycle in HALT, or
- on the next cycle when clear is applied.
REQ-023 div_load in the same cycle as a wrap SHALL take effect on the following wrap; the current period is not modified.
REQ-024 clear SHALL zero the phase counter and suppress the tick for that cycle.
- clear has priority over a wrap and over enable.
- clear does not alter tick_count or clk_out.
REQ-025 tick_count SHALL increment by 1 on every tick and wrap from 2^CNT_W-1 to 0.
REQ-026 In HALT, the counter SHALL stay at 0, with no tick, busy=0 and all outputs held.
REQ-027 Priority SHALL be: reset > clear > div_load apply > count/tick.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL set:
- state = RUN, phase counter = 0;
- div_cur = pending divisor = DIV_DEFAULT (0 mapped to 1);
- tick = 0, clk_out = 0, tick_count = 0, busy = 1.
REQ-029 Reset asserted mid-period SHALL abandon the period and discard any pending divisor; the first tick after release SHALL come div_cur enabled cycles later.

Configuration
REQ-030 Macro TICK_DIVIDER_CLKOUT_EN:
- When defined, clk_out SHALL be a register toggling on every tick (period 2*div_cur, 50% duty).
- When undefined, clk_out SHALL be tied to 0 and its toggle register SHALL not be built.
- tick behaviour SHALL be identical in both builds.

Verification
REQ-031 DIV_DEFAULT=4, enable=1 after reset -> tick on cycles 4, 8, 12 after release; clk_out toggles at each tick; tick_count = 3 after 12 cycles.
REQ-032 div=5, div_load with div_in=2 at cycle 2 -> current period completes at 5 cycles, then ticks every 2 cycles; div_cur changes in the cycle after the wrap.
REQ-033 div=3, oneshot=1 -> exactly one tick, then busy=0 and no ticks for 20 cycles; clear -> busy=1 and the next tick 3 cycles later.
REQ-034 div=6, enable low for 10 cycles at count 2 -> tick delayed by exactly 10 cycles; clear coinciding with the wrap -> no tick and the counter restarts from 0.
REQ-035 CNT_W=4, div=1 -> tick every cycle; tick_count wraps 15 -> 0 on the 16th tick; div_in=0 loaded -> div_cur=1.
REQ-036 Reset asserted at count 3 of div=8 with a pending div_in=2 -> div_cur=DIV_DEFAULT, outputs at reset values, and the pending value is discarded; run both with and without TICK_DIVIDER_CLKOUT_EN and check that tick traces are identical.
